button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_BTN, 4: number of push-button channels.
- ACTIVE_LOW, 1: raw inputs read 0 when pressed.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples needed to accept a change (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000: hold cycles from press to first repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses; minimum 1.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_clk, in, 1: system clock. One clock, all logic on its rising edge.
- reset_reset, in, 1: reset, synchronous and active-high.
- btn_raw, in, N_BTN: asynchronous raw key pins.
- btn_level, out, N_BTN: debounced state, 1 = pressed; feeds the system buttons_export input.
- btn_press, out, N_BTN: one-cycle pulse on accepted press.
- btn_release, out, N_BTN: one-cycle pulse on accepted release.
- btn_repeat, out, N_BTN: one-cycle auto-repeat pulse while held.
- evt_pending, out, N_BTN: sticky press-event flags.
- evt_clear, in, N_BTN: one-cycle clear strobe per flag.

Function
REQ-003 Each channel has a 2-flop synchronizer on btn_raw, followed by normalisation to 1 = pressed when ACTIVE_LOW=1. Channels are fully independent.
REQ-004 Debounce: a per-channel counter increments each cycle the synchronized sample differs from btn_level, and clears to 0 on any cycle they match.
REQ-005 When the counter equals DEBOUNCE_CYCLES-1 and a mismatch is still present, btn_level toggles and the counter clears on that same edge.
REQ-006 Latency: a clean raw change set up before edge 0 is visible on btn_level after edge DEBOUNCE_CYCLES+1. Any glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
REQ-007 btn_press (btn_release) is asserted for exactly one cycle: the same cycle btn_level becomes 1 (0). Press and release are never asserted together on one channel.
REQ-008 Per-channel state machine:
- RELEASED -> HELD_DELAY on accepted press; hold counter loaded 0.
- HELD_DELAY -> HELD_REPEAT when the hold counter reaches REPEAT_DELAY-1; btn_repeat pulses on that transition.
- HELD_REPEAT: btn_repeat pulses once every REPEAT_PERIOD cycles.
- Any state -> RELEASED on accepted release; the hold counter clears.
REQ-009 With REPEAT_DELAY=0, HELD_DELAY persists until release and btn_repeat never asserts.
REQ-010 Hold and debounce counters are sized by ceiling log2 of their terminal values. They never wrap: they stop at terminal count or reload.
REQ-011 evt_pending[i] sets on btn_press[i] and clears on evt_clear[i]. If set and clear occur in the same cycle, set wins and the flag stays 1. Repeat pulses do not set the flag.
REQ-012 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-013 While reset_reset=1 at a rising edge, all of the following go to the released state / 0:
- synchronizer flops (released state, i.e. 1 when ACTIVE_LOW=1)
- btn_level
- all counters
- state = RELEASED
- btn_press, btn_release, btn_repeat, evt_pending
REQ-014 Reset has priority over every other event, including evt_clear and pending counter terminal counts.
REQ-015 A button physically held through reset deassertion is treated as a new press: btn_press fires DEBOUNCE_CYCLES+2 edges after reset falls.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1.
REQ-016 Clean press: btn_raw[0] 1->0 before edge 0, held -> btn_level[0]=1 and btn_press[0]=1 after edge 5, for one cycle only; evt_pending[0]=1 from then on.
REQ-017 Glitch rejection: btn_raw[1] low for 3 cycles, then high -> btn_level[1], btn_press[1] and evt_pending[1] stay 0 throughout.
REQ-018 Auto-repeat: btn_raw[2] held low 40 cycles after the press pulse -> btn_repeat[2] pulses 10 cycles after btn_press[2], then every 3 cycles. Release -> btn_release[2] pulse, and no further repeats.
REQ-019 Set/clear collision: evt_clear[0]=1 asserted in the same cycle as btn_press[0] -> evt_pending[0] remains 1. evt_clear[0] on a later cycle -> evt_pending[0]=0 on the next edge.
REQ-020 Reset mid-hold: reset_reset pulsed for 2 cycles while btn_raw[3]=0 in HELD_REPEAT -> all outputs 0 during reset. btn_press[3] re-fires 6 edges after reset deasserts.
REQ-021 Simultaneous channels: all four buttons pressed on the same cycle -> btn_press=4'b1111 on a single cycle and btn_level=4'b1111.

Source files
------------

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: 2-flop synchronizer, debounce, press/release
// pulses, hold/auto-repeat state machine and sticky press-event flags.
module button_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] evt_pending,
  input  logic [N_BTN-1:0] evt_clear
);

  localparam logic [N_BTN-1:0] IDLE_RAW = ACTIVE_LOW ? '1 : '0;
  localparam int unsigned DBW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [DBW-1:0] DB_TERM     = DBW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [HW-1:0]  DELAY_TERM  = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0]  PERIOD_TERM = HW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_HELD_DELAY,
    ST_HELD_REPEAT
  } hold_state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q, sample;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [DBW-1:0]   db_cnt_q   [N_BTN];
  logic [DBW-1:0]   db_cnt_d   [N_BTN];
  logic [HW-1:0]    hold_cnt_q [N_BTN];
  logic [HW-1:0]    hold_cnt_d [N_BTN];
  hold_state_e      state_q    [N_BTN];
  hold_state_e      state_d    [N_BTN];

  assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    state_d    = state_q;
    // Flag set is taken from the visible press pulse so a clear in that same cycle loses.
    pend_d = press_q | (pend_q & ~evt_clear);
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (sample[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_TERM) begin
          level_d[i]   = sample[i];
          press_d[i]   = sample[i];
          release_d[i] = ~sample[i];
          db_cnt_d[i]  = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      if (release_d[i]) begin
        state_d[i]    = ST_RELEASED;
        hold_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_RELEASED: begin
            if (press_d[i]) begin
              state_d[i]    = ST_HELD_DELAY;
              hold_cnt_d[i] = '0;
            end
          end
          ST_HELD_DELAY: begin
            if (REPEAT_DELAY != 0) begin
              if (hold_cnt_q[i] == DELAY_TERM) begin
                state_d[i]    = ST_HELD_REPEAT;
                hold_cnt_d[i] = '0;
                repeat_d[i]   = 1'b1;
              end else begin
                hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
              end
            end
          end
          ST_HELD_REPEAT: begin
            if (hold_cnt_q[i] == PERIOD_TERM) begin
              hold_cnt_d[i] = '0;
              repeat_d[i]   = 1'b1;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i]    = ST_RELEASED;
            hold_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q   <= IDLE_RAW;
      sync2_q   <= IDLE_RAW;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      pend_q    <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= ST_RELEASED;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      pend_q     <= pend_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign evt_pending = pend_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat, evt_pending;
  logic [3:0] evt_clear;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN(4),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat),
    .evt_pending(evt_pending),
    .evt_clear(evt_clear)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] pnd;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " level"},   {28'd0, btn_level},   32'd0);
    chk({nm, " press"},   {28'd0, btn_press},   32'd0);
    chk({nm, " release"}, {28'd0, btn_release}, 32'd0);
    chk({nm, " repeat"},  {28'd0, btn_repeat},  32'd0);
    chk({nm, " pending"}, {28'd0, evt_pending}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0 clean press / clear collision / release; ch1 3-cycle glitch
    tbl[0]  = '{raw:4'b1100, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[1]  = '{raw:4'b1100, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[2]  = '{raw:4'b1100, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[3]  = '{raw:4'b1110, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[4]  = '{raw:4'b1110, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[5]  = '{raw:4'b1110, clr:4'b0000, lvl:4'b0001, prs:4'b0001, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[6]  = '{raw:4'b1110, clr:4'b0001, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0001};
    tbl[7]  = '{raw:4'b1110, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0001};
    tbl[8]  = '{raw:4'b1110, clr:4'b0001, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[9]  = '{raw:4'b1111, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[10] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[11] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[12] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[13] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0001, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};
    tbl[14] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0001, rpt:4'b0000, pnd:4'b0000};
    tbl[15] = '{raw:4'b1111, clr:4'b0000, lvl:4'b0000, prs:4'b0000, rel:4'b0000, rpt:4'b0000, pnd:4'b0000};

    reset_reset = 1'b1;
    btn_raw     = 4'b1111;
    evt_clear   = 4'b0000;
    step(); step(); step();
    chk_all_zero("reset");

    reset_reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      btn_raw   = tbl[r].raw;
      evt_clear = tbl[r].clr;
      step();
      chk($sformatf("row%0d level", r),   {28'd0, btn_level},   {28'd0, tbl[r].lvl});
      chk($sformatf("row%0d press", r),   {28'd0, btn_press},   {28'd0, tbl[r].prs});
      chk($sformatf("row%0d release", r), {28'd0, btn_release}, {28'd0, tbl[r].rel});
      chk($sformatf("row%0d repeat", r),  {28'd0, btn_repeat},  {28'd0, tbl[r].rpt});
      chk($sformatf("row%0d pending", r), {28'd0, evt_pending}, {28'd0, tbl[r].pnd});
    end
    evt_clear = 4'b0000;

    // Auto-repeat on ch2: press after 6 edges, repeat at +10 then every 3, release after hold
    btn_raw = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rpt press k%0d", k), {31'd0, btn_press[2]}, (k == 6) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 57; k++) begin
      bit exp_rpt;
      step();
      exp_rpt = (k < 47) && (k >= 10) && (((k - 10) % 3) == 0);
      chk($sformatf("rpt repeat k%0d", k),  {31'd0, btn_repeat[2]},  {31'd0, exp_rpt});
      chk($sformatf("rpt release k%0d", k), {31'd0, btn_release[2]}, (k == 47) ? 32'd1 : 32'd0);
      chk($sformatf("rpt level k%0d", k),   {31'd0, btn_level[2]},   (k < 47) ? 32'd1 : 32'd0);
      if (k == 41) btn_raw = 4'b1111;
    end

    // Reset while ch3 is in the repeat phase; held button re-fires 6 edges after reset falls
    btn_raw = 4'b0111;
    for (int k = 0; k < 21; k++) step();
    chk("mid-hold level3", {31'd0, btn_level[3]}, 32'd1);
    reset_reset = 1'b1;
    step();
    chk_all_zero("reset1");
    step();
    chk_all_zero("reset2");
    reset_reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("rst press k%0d", k), {28'd0, btn_press}, (k == 6) ? 32'h8 : 32'h0);
      chk($sformatf("rst level k%0d", k), {28'd0, btn_level}, (k >= 6) ? 32'h8 : 32'h0);
    end

    // All four channels pressed together
    btn_raw     = 4'b1111;
    reset_reset = 1'b1;
    step(); step();
    reset_reset = 1'b0;
    btn_raw     = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("all press k%0d", k), {28'd0, btn_press}, (k == 6) ? 32'hF : 32'h0);
      chk($sformatf("all level k%0d", k), {28'd0, btn_level}, (k >= 6) ? 32'hF : 32'h0);
      chk($sformatf("all pending k%0d", k), {28'd0, evt_pending}, (k >= 7) ? 32'hF : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
